// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART TX byte port among NUM_REQ byte-stream requesters.
//   The arbiter picks round-robin and then locks the grant for a whole packet. The owner
//   keeps the UART until one of three things happens:
//     - it sends a byte marked last,
//     - it has sent MAX_BURST bytes, or
//     - it leaves valid low in SEND for IDLE_TIMEOUT cycles.
//   After any release the pointer moves to the slot after the owner.
//
// Ports
//   ACLK, ARESETn           clock; asynchronous active-low reset
//   req_valid/data/last     per-requester byte stream; requester i uses req_data[8i+:8]
//   req_ready               one-hot; byte of the owner accepted this cycle
//   tx_dv, tx_byte          start pulse and byte to the UART TX core
//   tx_active, tx_done      UART core busy flag and end-of-stop-bit pulse
//   grant_id, busy          current owner index and grant-held flag
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_dv,
    output logic [7:0]           tx_byte,
    input  logic                 tx_active,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 busy
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] grant_q, grant_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic [9:0] idle_cnt_q, idle_cnt_d;
    logic       last_q, last_d;
    logic [7:0] tx_byte_q, tx_byte_d;

    // Round-robin candidate search starting at ptr_q.
    logic       pick_found;
    logic [2:0] pick_idx;
    logic [3:0] cand;
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + 4'(k);
            if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pick_found && cand == 4'(j) && req_valid[j]) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(j);
                end
            end
        end
    end

    // Owner's stream, selected by the registered grant.
    logic               g_valid, g_last;
    logic [7:0]         g_data;
    logic [NUM_REQ-1:0] g_onehot;
    always_comb begin
        g_valid  = 1'b0;
        g_last   = 1'b0;
        g_data   = '0;
        g_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_q == 3'(k)) begin
                g_valid     = req_valid[k];
                g_last      = req_last[k];
                g_data      = req_data[8*k +: 8];
                g_onehot[k] = 1'b1;
            end
        end
    end

    logic [2:0] ptr_next;
    assign ptr_next = (grant_q == 3'(NUM_REQ-1)) ? 3'd0 : grant_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        last_d      = last_q;
        tx_byte_d   = tx_byte_q;
        tx_dv       = 1'b0;
        req_ready   = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d     = pick_idx;
                    burst_cnt_d = '0;
                    idle_cnt_d  = '0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                if (g_valid) begin
                    // A valid byte held back by a busy UART is not an owner stall,
                    // so the idle counter only advances while valid is low.
                    if (!tx_active) begin
                        tx_dv       = 1'b1;
                        req_ready   = g_onehot;
                        tx_byte_d   = g_data;
                        last_d      = g_last;
                        burst_cnt_d = burst_cnt_q + 8'd1;
                        idle_cnt_d  = '0;
                        state_d     = S_WAIT;
                    end
                end else if (idle_cnt_q == 10'(IDLE_TIMEOUT-1)) begin
                    idle_cnt_d = '0;
                    ptr_d      = ptr_next;
                    state_d    = S_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 10'd1;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    // A last flag and a full burst together still give only one release.
                    if (last_q || burst_cnt_q == 8'(MAX_BURST)) begin
                        ptr_d   = ptr_next;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
            last_q      <= 1'b0;
            tx_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            last_q      <= last_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    // The byte passes straight through in the tx_dv cycle. The register then holds
    // it until tx_done.
    assign tx_byte  = tx_dv ? g_data : tx_byte_q;
    assign grant_id = grant_q;
    assign busy     = (state_q != S_IDLE);

endmodule
